branch_resolve_unit: RTL and testbench



---
 rtl/branch_resolve_unit.sv | 176 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: mispredict redirect/flush, wrong-path suppression and an
// in-order predictor-update FIFO. Define BRU_STATS_EN to add saturating branch/mispredict counters.
module branch_resolve_unit #(
  parameter int unsigned UPD_DEPTH      = 4,
  parameter int unsigned RECOVER_CYCLES = 3,
  parameter int unsigned SIZE_PC        = 32,
  parameter int unsigned SIZE_TAG       = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                exe_valid_i,
  input  logic [SIZE_PC-1:0]  exe_pc_i,
  input  logic [SIZE_PC-1:0]  exe_nextPC_i,
  input  logic                exe_direction_i,
  input  logic [7:0]          exe_flags_i,
  input  logic [SIZE_TAG-1:0] exe_tag_i,
  output logic                redirect_valid_o,
  output logic [SIZE_PC-1:0]  redirect_pc_o,
  output logic [SIZE_TAG-1:0] flush_tag_o,
  output logic                upd_valid_o,
  output logic [SIZE_PC-1:0]  upd_pc_o,
  output logic [SIZE_PC-1:0]  upd_target_o,
  output logic                upd_dir_o,
  input  logic                upd_ready_i,
  output logic                stall_o,
`ifdef BRU_STATS_EN
  output logic [31:0]         stat_branches_o,
  output logic [31:0]         stat_mispredicts_o,
`endif
  output logic                overflow_o
);

  localparam int unsigned PtrW = $clog2(UPD_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned RcW  = $clog2(RECOVER_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StRedirect, StRecover} state_e;

  typedef struct packed {
    logic [SIZE_PC-1:0] pc;
    logic [SIZE_PC-1:0] target;
    logic               dir;
  } upd_entry_t;

  state_e              state_q, state_d;
  logic [RcW-1:0]      rcnt_q, rcnt_d;
  logic                redir_q, redir_d;
  logic [SIZE_PC-1:0]  rpc_q, rpc_d;
  logic [SIZE_TAG-1:0] tag_q, tag_d;

  upd_entry_t          mem_q [UPD_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;

  logic honour, push, mispred, pop, full, push_ok;
  logic unused_flags;

  assign unused_flags = ^{exe_flags_i[7:6], exe_flags_i[4:3], exe_flags_i[1]};

  always_comb begin
    honour  = exe_valid_i && exe_flags_i[2] && (state_q == StIdle);
    push    = honour && exe_flags_i[5];
    mispred = honour && exe_flags_i[0];
    pop     = valid_q && upd_ready_i;
    full    = (count_q == CntW'(UPD_DEPTH));
    // A pop in the same cycle frees the slot the push lands in.
    push_ok = push && (!full || pop);
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    redir_d = 1'b0;
    rpc_d   = rpc_q;
    tag_d   = tag_q;
    case (state_q)
      StIdle: begin
        if (mispred) begin
          state_d = StRedirect;
          redir_d = 1'b1;
          rpc_d   = exe_nextPC_i;
          tag_d   = exe_tag_i;
        end
      end
      StRedirect: begin
        state_d = StRecover;
        rcnt_d  = RcW'(RECOVER_CYCLES);
      end
      StRecover: begin
        rcnt_d = rcnt_q - RcW'(1);
        if (rcnt_q == RcW'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push_ok) - CntW'(pop);
    valid_d  = (count_d != '0);
    ovf_d    = ovf_q | (push && full && !pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      rcnt_q   <= '0;
      redir_q  <= 1'b0;
      rpc_q    <= '0;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      redir_q  <= redir_d;
      rpc_q    <= rpc_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; contents are only observed behind upd_valid_o.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= '{pc: exe_pc_i, target: exe_nextPC_i, dir: exe_direction_i};
    end
  end

  assign redirect_valid_o = redir_q;
  assign redirect_pc_o    = rpc_q;
  assign flush_tag_o      = tag_q;
  assign upd_valid_o      = valid_q;
  assign upd_pc_o         = mem_q[rd_ptr_q].pc;
  assign upd_target_o     = mem_q[rd_ptr_q].target;
  assign upd_dir_o        = mem_q[rd_ptr_q].dir;
  assign stall_o          = full;
  assign overflow_o       = ovf_q;

`ifdef BRU_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (push && (stat_br_q != '1)) stat_br_d = stat_br_q + 32'd1;
    if (mispred && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by random traffic,
// compared every cycle against a cycle-count/queue reference model.
module tb_branch_resolve_unit;

  localparam int unsigned Depth = 4;
  localparam int unsigned Rc    = 3;
  localparam int unsigned PcW   = 32;
  localparam int unsigned TagW  = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic            exe_valid_i;
  logic [PcW-1:0]  exe_pc_i;
  logic [PcW-1:0]  exe_nextPC_i;
  logic            exe_direction_i;
  logic [7:0]      exe_flags_i;
  logic [TagW-1:0] exe_tag_i;
  logic            redirect_valid_o;
  logic [PcW-1:0]  redirect_pc_o;
  logic [TagW-1:0] flush_tag_o;
  logic            upd_valid_o;
  logic [PcW-1:0]  upd_pc_o;
  logic [PcW-1:0]  upd_target_o;
  logic            upd_dir_o;
  logic            upd_ready_i;
  logic            stall_o;
  logic            overflow_o;
`ifdef BRU_STATS_EN
  logic [31:0]     stat_branches_o;
  logic [31:0]     stat_mispredicts_o;
`endif

  branch_resolve_unit #(
    .UPD_DEPTH      (Depth),
    .RECOVER_CYCLES (Rc),
    .SIZE_PC        (PcW),
    .SIZE_TAG       (TagW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .exe_valid_i      (exe_valid_i),
    .exe_pc_i         (exe_pc_i),
    .exe_nextPC_i     (exe_nextPC_i),
    .exe_direction_i  (exe_direction_i),
    .exe_flags_i      (exe_flags_i),
    .exe_tag_i        (exe_tag_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .flush_tag_o      (flush_tag_o),
    .upd_valid_o      (upd_valid_o),
    .upd_pc_o         (upd_pc_o),
    .upd_target_o     (upd_target_o),
    .upd_dir_o        (upd_dir_o),
    .upd_ready_i      (upd_ready_i),
    .stall_o          (stall_o),
`ifdef BRU_STATS_EN
    .stat_branches_o    (stat_branches_o),
    .stat_mispredicts_o (stat_mispredicts_o),
`endif
    .overflow_o       (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PcW-1:0] pc;
    logic [PcW-1:0] tgt;
    logic           dir;
  } upd_t;

  // Reference model: pending updates, sticky overflow, last redirect, and the first cycle
  // index at which inputs are honoured again.
  upd_t            mq[$];
  bit              m_ovf;
  bit              m_redir;
  logic [PcW-1:0]  m_rpc;
  logic [TagW-1:0] m_tag;
  int              cyc;
  int              honour_from;

  int n_cmp;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("redirect_valid", 64'(redirect_valid_o), 64'(m_redir));
    chk("redirect_pc", 64'(redirect_pc_o), 64'(m_rpc));
    chk("flush_tag", 64'(flush_tag_o), 64'(m_tag));
    chk("upd_valid", 64'(upd_valid_o), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("upd_pc", 64'(upd_pc_o), 64'(mq[0].pc));
      chk("upd_target", 64'(upd_target_o), 64'(mq[0].tgt));
      chk("upd_dir", 64'(upd_dir_o), 64'(mq[0].dir));
    end
    chk("stall", 64'(stall_o), 64'(mq.size() == Depth));
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
  endtask

  task automatic model_edge();
    bit pop;
    bit acc;
    pop = (mq.size() != 0) && upd_ready_i;
    acc = exe_valid_i && exe_flags_i[2] && (cyc >= honour_from);
    m_redir = 1'b0;
    if (pop) void'(mq.pop_front());
    if (acc && exe_flags_i[5]) begin
      if (mq.size() < Depth) mq.push_back('{pc: exe_pc_i, tgt: exe_nextPC_i, dir: exe_direction_i});
      else m_ovf = 1'b1;
    end
    if (acc && exe_flags_i[0]) begin
      m_redir     = 1'b1;
      m_rpc       = exe_nextPC_i;
      m_tag       = exe_tag_i;
      honour_from = cyc + 2 + Rc;
    end
    cyc++;
  endtask

  task automatic step(input logic v, input logic [PcW-1:0] pc, input logic [PcW-1:0] npc,
                      input logic dir, input logic [7:0] fl, input logic [TagW-1:0] tag,
                      input logic rdy);
    exe_valid_i     = v;
    exe_pc_i        = pc;
    exe_nextPC_i    = npc;
    exe_direction_i = dir;
    exe_flags_i     = fl;
    exe_tag_i       = tag;
    upd_ready_i     = rdy;
    check_outputs();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, 1'b0, 8'h00, '0, rdy);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    exe_valid_i = 1'b0;
    upd_ready_i = 1'b0;
    #1;
    chk("rst_redirect_valid", 64'(redirect_valid_o), 64'd0);
    chk("rst_upd_valid", 64'(upd_valid_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    m_ovf       = 1'b0;
    m_redir     = 1'b0;
    m_rpc       = '0;
    m_tag       = '0;
    honour_from = cyc;
  endtask

  initial begin
    logic [7:0] fl;
    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    honour_from = 0;
    reset = 1'b0;
    exe_valid_i = 1'b0;
    exe_pc_i = '0;
    exe_nextPC_i = '0;
    exe_direction_i = 1'b0;
    exe_flags_i = '0;
    exe_tag_i = '0;
    upd_ready_i = 1'b0;
    @(negedge clk);
    do_reset();

    // Correct prediction
    step(1'b1, 32'h0040_0100, 32'h0040_0108, 1'b1, 8'hA4, 7'd3, 1'b0);
    chk("cp_upd_valid", 64'(upd_valid_o), 64'd1);
    chk("cp_upd_pc", 64'(upd_pc_o), 64'h0040_0100);
    chk("cp_upd_target", 64'(upd_target_o), 64'h0040_0108);
    chk("cp_no_redirect", 64'(redirect_valid_o), 64'd0);

    // Mispredict, then four suppressed mispredicts, then an honoured one
    step(1'b1, 32'h0040_0180, 32'h0040_0200, 1'b0, 8'hA5, 7'd5, 1'b0);
    chk("mp_redirect", 64'(redirect_valid_o), 64'd1);
    chk("mp_redirect_pc", 64'(redirect_pc_o), 64'h0040_0200);
    chk("mp_flush_tag", 64'(flush_tag_o), 64'd5);
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, $urandom, 1'b1, 8'hA5, 7'(i + 20), 1'b0);
    chk("rec_no_redirect", 64'(redirect_valid_o), 64'd0);
    step(1'b1, 32'h0040_0300, 32'h0040_0400, 1'b1, 8'hA5, 7'd9, 1'b0);
    chk("rec_honoured", 64'(redirect_valid_o), 64'd1);
    chk("rec_flush_tag", 64'(flush_tag_o), 64'd9);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Fill to full, overflow, drain in order
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h1000 + 32'(i * 4), $urandom, i[0], 8'hA4, '0, 1'b0);
    chk("fill_stall", 64'(stall_o), 64'd1);
    step(1'b1, 32'h2000, 32'h2004, 1'b1, 8'hA4, '0, 1'b0);
    chk("fill_overflow", 64'(overflow_o), 64'd1);
    chk("fill_stall_kept", 64'(stall_o), 64'd1);
    chk("fill_head", 64'(upd_pc_o), 64'h1000);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h3000 + 32'(i * 4), $urandom, 1'b0, 8'hA4, '0, 1'b0);
    step(1'b1, 32'h3100, 32'h3104, 1'b1, 8'hA4, '0, 1'b1);
    chk("pp_stall", 64'(stall_o), 64'd1);
    chk("pp_overflow", 64'(overflow_o), 64'd0);
    chk("pp_head", 64'(upd_pc_o), 64'h3004);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Reset while recovering
    step(1'b1, 32'h5000, 32'h5100, 1'b1, 8'hA5, 7'd7, 1'b0);
    idle(1'b0);
    idle(1'b0);
    do_reset();
    chk("rr_upd_valid", 64'(upd_valid_o), 64'd0);
    step(1'b1, 32'h6000, 32'h6200, 1'b1, 8'hA5, 7'd11, 1'b1);
    chk("rr_redirect", 64'(redirect_valid_o), 64'd1);
    chk("rr_flush_tag", 64'(flush_tag_o), 64'd11);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      fl = 8'($urandom);
      fl[2] = ($urandom_range(0, 9) != 0);
      fl[0] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 149) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom_range(0, 1)), fl,
           7'($urandom), $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 8; i++) idle(1'b1);
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
